// File: rtl/hidden_prog_feeder_pkg.sv
// Shared constants for the HiddenCPU program feeder: FSM encoding, pin map of
// the CPU input byte and the instruction field layout.
package hidden_prog_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CPU_RST,
      ST_RUN,
      ST_HALT
   } state_t;

   localparam int PIN_W         = 8;
   localparam int CPU_CLK_BIT   = 0;
   localparam int CPU_RST_BIT   = 1;
   localparam int CPU_INSTR_LSB = 2;

   localparam int OPCODE_W   = 2;
   localparam int REG_ADDR_W = 2;
   localparam int INSTR_W    = OPCODE_W + 2 * REG_ADDR_W;

endpackage

// File: rtl/hidden_cpu_clk_gen.sv
// Phase counter for the generated CPU clock: one CPU period is 2*CLK_DIV
// system cycles, low for the first half and high for the second.
module hidden_cpu_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic cpu_clk_level,
   output logic period_start,
   output logic rise,
   output logic period_end
);

   localparam int PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

   logic [PH_W-1:0] ph;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ph <= '0;
      else if (clr)
         ph <= '0;
      else if (en)
         ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
   end

   assign cpu_clk_level = (ph >= PH_RISE);
   assign period_start  = (ph == '0);
   assign rise          = (ph == PH_RISE);
   assign period_end    = (ph == PH_LAST);

endmodule

// File: rtl/hidden_prog_feeder.sv
// Host-side sequencer for the HiddenCPU pin interface: buffers a program over a
// ready/valid port, resets the CPU, then feeds mem[PC] once per CPU clock period.
module hidden_prog_feeder
   import hidden_prog_feeder_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int CLK_DIV = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   input  logic               start,
   input  logic               stop,
   input  logic [PIN_W-1:0]   cpu_out,
   output logic [PIN_W-1:0]   cpu_in,
   output logic [ADDR_W:0]    prog_len,
   output logic               busy,
   output logic               halted,
   output logic [15:0]        cpu_cycles
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] FULL_LEN  = PTR_W'(DEPTH);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t             state;
   logic [PTR_W-1:0]   wr_ptr;
   logic [INSTR_W-1:0] mem [DEPTH];

   logic              in_run;
   logic              accept;
   logic              past_end;
   logic              halt_req;
   logic [ADDR_W-1:0] wr_addr;
   logic              cpu_clk_level;
   logic              period_start;
   logic              rise;
   logic              period_end;

   assign in_run   = (state == ST_CPU_RST) || (state == ST_RUN);
   assign accept   = load_valid && load_ready && !in_run;
   assign wr_addr  = (state == ST_LOAD) ? wr_ptr[ADDR_W-1:0] : '0;
   assign past_end = (cpu_out >= PIN_W'(prog_len));
   assign halt_req = in_run && (stop || (state == ST_RUN && period_start && past_end));

   // cpu_in lags the phase counter by one cycle, so the decision made at
   // period_start lands on the same edge as the CPU-visible period boundary.
   hidden_cpu_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_gen (
      .clk          (clk),
      .rst          (rst),
      .en           (in_run),
      .clr          (!in_run || stop),
      .cpu_clk_level(cpu_clk_level),
      .period_start (period_start),
      .rise         (rise),
      .period_end   (period_end)
   );

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_addr] <= load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cpu_in     <= '0;
         wr_ptr     <= '0;
         prog_len   <= '0;
         cpu_cycles <= '0;
         busy       <= 1'b0;
         halted     <= 1'b0;
         load_ready <= 1'b1;
      end else if (halt_req) begin
         state      <= ST_HALT;
         cpu_in     <= '0;
         busy       <= 1'b0;
         halted     <= 1'b1;
         load_ready <= 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               load_ready <= 1'b1;
               if (accept) begin
                  halted <= 1'b0;
                  wr_ptr <= PTR_W'(1);
                  if (load_last) begin
                     prog_len <= PTR_W'(1);
                     state    <= ST_IDLE;
                  end else begin
                     state <= ST_LOAD;
                  end
               end else if (start && !load_valid && prog_len != '0 &&
                            !(state == ST_HALT && stop)) begin
                  state      <= ST_CPU_RST;
                  busy       <= 1'b1;
                  halted     <= 1'b0;
                  load_ready <= 1'b0;
                  cpu_cycles <= '0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + PTR_W'(1);
                  if (load_last) begin
                     prog_len <= wr_ptr + PTR_W'(1);
                     state    <= ST_IDLE;
                  end else if (wr_ptr == LAST_SLOT) begin
                     prog_len   <= FULL_LEN;
                     state      <= ST_IDLE;
                     load_ready <= 1'b0;
                  end
               end
            end
            ST_CPU_RST: begin
               cpu_in[CPU_CLK_BIT] <= cpu_clk_level;
               if (period_start) begin
                  cpu_in[CPU_RST_BIT]                 <= 1'b1;
                  cpu_in[PIN_W-1:CPU_INSTR_LSB] <= '0;
               end
               if (rise)
                  cpu_cycles <= sat_inc16(cpu_cycles);
               if (period_end)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               cpu_in[CPU_CLK_BIT] <= cpu_clk_level;
               if (period_start) begin
                  cpu_in[CPU_RST_BIT]                 <= 1'b0;
                  cpu_in[PIN_W-1:CPU_INSTR_LSB] <= mem[cpu_out[ADDR_W-1:0]];
               end
               if (rise)
                  cpu_cycles <= sat_inc16(cpu_cycles);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hidden_prog_feeder.sv
// Bench for hidden_prog_feeder: directed load/run/stop/reset steps plus random
// programs executed by an abstract CPU that follows a precomputed PC path.
module tb_hidden_prog_feeder;

   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int CLK_DIV = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [5:0]  load_data;
   logic        load_last;
   logic        start;
   logic        stop;
   logic [7:0]  cpu_out;
   logic [7:0]  cpu_in;
   logic [4:0]  prog_len;
   logic        busy;
   logic        halted;
   logic [15:0] cpu_cycles;

   int tests = 0;
   int fails = 0;

   logic [5:0] model_mem [DEPTH];
   int         model_len = 0;

   always #5 clk = ~clk;

   hidden_prog_feeder #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .load_last (load_last),
      .start     (start),
      .stop      (stop),
      .cpu_out   (cpu_out),
      .cpu_in    (cpu_in),
      .prog_len  (prog_len),
      .busy      (busy),
      .halted    (halted),
      .cpu_cycles(cpu_cycles)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_prog(input int n);
      for (int i = 0; i < n; i++)
         model_mem[i] = 6'($urandom_range(0, 63));
   endtask

   // Sends model_mem[first..n-1] with random idle gaps; a beat counts as taken
   // when load_ready was high while it was presented.
   task automatic load_prog(input int first, input int n, input bit use_last);
      int i;
      int guard;
      i = first;
      guard = 0;
      while (i < n && guard < 400) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            load_valid = 1'b0;
            load_last  = 1'b0;
         end else begin
            load_valid = 1'b1;
            load_data  = model_mem[i];
            load_last  = use_last && (i == n - 1);
            if (load_ready) i++;
         end
         guard++;
      end
      check("load_beats", 32'(i), 32'(n));
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (use_last || n == DEPTH) model_len = n;
   endtask

   // Starts a run and plays a PC path: each run rise executes the instruction at
   // the current PC, after which the CPU presents the next PC of the path.
   task automatic run_prog(input bit directed);
      int   path[$];
      int   pc;
      int   n;
      int   k;
      int   rst_cyc;
      int   rst_rise;
      bit   done;
      logic prev;
      path.delete();
      path.push_back(0);
      pc = 0;
      while (pc < model_len) begin
         if (directed)
            pc = pc + 1;
         else if (path.size() > 20)
            pc = int'($urandom_range(model_len, 255));
         else begin
            case ($urandom_range(0, 9))
               0:       pc = int'($urandom_range(model_len, 255));
               1, 2:    pc = int'($urandom_range(0, model_len));
               default: pc = pc + 1;
            endcase
         end
         path.push_back(pc);
      end
      n = path.size() - 1;
      k = 0;
      rst_cyc = 0;
      rst_rise = 0;
      done = 1'b0;
      prev = 1'b0;
      @(negedge clk);
      cpu_out = 8'($urandom_range(0, 255));
      start = 1'b1;
      for (int cyc = 0; cyc < 4 * CLK_DIV * (n + 3) + 10 && !done; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cpu_in[1]) rst_cyc++;
         if (cpu_in[0] && !prev) begin
            if (cpu_in[1]) begin
               rst_rise++;
               cpu_out = 8'(path[0]);
            end else begin
               k++;
               if (k <= n) begin
                  check("run_instr", 32'(cpu_in[7:2]), 32'(model_mem[path[k-1]]));
                  cpu_out = 8'(path[k]);
               end
            end
         end
         prev = cpu_in[0];
         if (halted) done = 1'b1;
      end
      check("run_halted", 32'(done), 32'd1);
      check("run_rises", 32'(k), 32'(n));
      check("run_rst_cycles", 32'(rst_cyc), 32'(2 * CLK_DIV));
      check("run_rst_rises", 32'(rst_rise), 32'd1);
      check("run_cpu_cycles", 32'(cpu_cycles), 32'(n + 1));
      check("run_cpu_in_idle", 32'(cpu_in), 32'd0);
      check("run_busy_off", 32'(busy), 32'd0);
   endtask

   initial begin
      bit found;
      int len;
      bit use_last;

      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      cpu_out    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cpu_in", 32'(cpu_in), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd1);
      check("rst_prog_len", 32'(prog_len), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_cpu_cycles", 32'(cpu_cycles), 32'd0);

      // start with an empty program is ignored
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("empty_start_busy", 32'(busy), 32'd0);
      check("empty_start_cpu_in", 32'(cpu_in), 32'd0);
      start = 1'b0;

      model_mem[0] = 6'h05;
      model_mem[1] = 6'h1A;
      model_mem[2] = 6'h3F;
      load_prog(0, 3, 1'b1);
      check("dir_prog_len", 32'(prog_len), 32'd3);
      check("dir_idle_busy", 32'(busy), 32'd0);
      check("dir_load_ready", 32'(load_ready), 32'd1);
      run_prog(1'b1);

      // stop during a high phase, stop beating start, then restart
      cpu_out = 8'h00;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (cpu_in[0] && !cpu_in[1] && busy) found = 1'b1;
      end
      check("stop_high_phase_seen", 32'(found), 32'd1);
      stop = 1'b1;
      @(negedge clk);
      check("stop_halted", 32'(halted), 32'd1);
      check("stop_cpu_in", 32'(cpu_in), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("stop_over_start_halted", 32'(halted), 32'd1);
      check("stop_over_start_busy", 32'(busy), 32'd0);
      stop = 1'b0;
      @(negedge clk);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_halted", 32'(halted), 32'd0);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (cpu_in[7:2] == 6'h05 && !cpu_in[1]) found = 1'b1;
      end
      check("restart_instr_seen", 32'(found), 32'd1);

      // asynchronous reset in the middle of a run
      #2 rst = 1'b1;
      #1;
      check("async_rst_cpu_in", 32'(cpu_in), 32'd0);
      check("async_rst_load_ready", 32'(load_ready), 32'd1);
      check("async_rst_prog_len", 32'(prog_len), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_cpu_cycles", 32'(cpu_cycles), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_len = 0;

      // fill the whole buffer without load_last; one extra beat is refused
      randomize_prog(DEPTH);
      load_prog(0, DEPTH, 1'b0);
      check("full_load_ready", 32'(load_ready), 32'd0);
      check("full_prog_len", 32'(prog_len), 32'(DEPTH));
      load_valid = 1'b1;
      load_data  = ~model_mem[0];
      @(negedge clk);
      load_valid = 1'b0;
      check("full_prog_len_kept", 32'(prog_len), 32'(DEPTH));
      check("full_busy", 32'(busy), 32'd0);
      run_prog(1'b0);

      // load beats priority over start when both arrive in IDLE
      len = int'($urandom_range(1, DEPTH));
      randomize_prog(len);
      load_prog(0, len, 1'b1);
      check("idle_prog_len", 32'(prog_len), 32'(len));
      len = int'($urandom_range(2, DEPTH));
      randomize_prog(len);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = model_mem[0];
      load_last  = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      start      = 1'b0;
      check("prio_busy", 32'(busy), 32'd0);
      check("prio_cpu_in", 32'(cpu_in), 32'd0);
      load_prog(1, len, 1'b1);
      check("prio_prog_len", 32'(prog_len), 32'(len));
      run_prog(1'b0);

      for (int t = 0; t < 6; t++) begin
         len = int'($urandom_range(1, DEPTH));
         use_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
         randomize_prog(len);
         load_prog(0, len, use_last);
         check("rand_prog_len", 32'(prog_len), 32'(len));
         run_prog(1'b0);
         if ($urandom_range(0, 1) == 1) run_prog(1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
